// File: rtl/ysyx_24120013_rf_access_ctrl.sv
// Register-file access sequencer: arbitrates the two RF read ports between the
// core operand reader and the debug port, hides read latency and bypasses same-edge writes.
module ysyx_24120013_rf_access_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_rs1,
  input  logic [ADDR_WIDTH-1:0] rd_rs2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_src1,
  output logic [DATA_WIDTH-1:0] rsp_src2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CORE_RD  = 2'd1,
    S_CORE_RSP = 2'd2,
    S_DBG_RD   = 2'd3
  } state_t;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_DBG  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] X0 = '0;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [ADDR_WIDTH-1:0] r_addr2;
  logic                  r_byp1;
  logic                  r_byp2;
  logic [DATA_WIDTH-1:0] r_byp_data;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_src1;
  logic [DATA_WIDTH-1:0] r_rsp_src2;
  logic                  r_dbg_ack;
  logic [DATA_WIDTH-1:0] r_dbg_data;

  logic                  w_idle;
  logic                  w_dbg_req;
  logic                  w_dbg_wins;
  logic                  w_rd_ready;
  logic                  w_gnt_core;
  logic                  w_gnt_dbg;
  logic [ADDR_WIDTH-1:0] w_cap1;
  logic                  w_byp1;
  logic                  w_byp2;
  logic [DATA_WIDTH-1:0] w_src1;
  logic [DATA_WIDTH-1:0] w_src2;

  // Write port is a pure pass-through; x0 writes are squashed here.
  assign rf_wen   = wb_valid && (wb_rd != X0);
  assign rf_waddr = wb_rd;
  assign rf_wdata = wb_data;

  // The request being acknowledged this cycle must not be re-granted.
  assign w_idle     = (r_state == S_IDLE);
  assign w_dbg_req  = dbg_req && !r_dbg_ack;
  assign w_dbg_wins = w_dbg_req && (!rd_valid || (r_last_grant == GNT_CORE));
  assign w_rd_ready = w_idle && !w_dbg_wins;
  assign w_gnt_core = w_rd_ready && rd_valid;
  assign w_gnt_dbg  = w_idle && w_dbg_wins;

  // RF returns the pre-write value on a shared edge, so remember the write.
  assign w_cap1 = w_gnt_dbg ? dbg_addr : rd_rs1;
  assign w_byp1 = wb_valid && (wb_rd == w_cap1) && (w_cap1 != X0);
  assign w_byp2 = wb_valid && (wb_rd == rd_rs2) && (rd_rs2 != X0) && w_gnt_core;

  assign w_src1 = (r_addr1 == X0) ? '0 : (r_byp1 ? r_byp_data : rf_rdata1);
  assign w_src2 = (r_addr2 == X0) ? '0 : (r_byp2 ? r_byp_data : rf_rdata2);

  always_comb begin
    rf_raddr1 = X0;
    rf_raddr2 = X0;
    if (w_gnt_core) begin
      rf_raddr1 = rd_rs1;
      rf_raddr2 = rd_rs2;
    end else if (w_gnt_dbg) begin
      rf_raddr1 = dbg_addr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_core)     w_state_nxt = S_CORE_RD;
        else if (w_gnt_dbg) w_state_nxt = S_DBG_RD;
      end
      S_CORE_RD:  w_state_nxt = S_CORE_RSP;
      S_CORE_RSP: if (rsp_ready) w_state_nxt = S_IDLE;
      S_DBG_RD:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= GNT_DBG;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_core)     r_last_grant <= GNT_CORE;
      else if (w_gnt_dbg) r_last_grant <= GNT_DBG;
    end
  end

  // Snapshot of the granted request: indices plus the same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr1    <= X0;
      r_addr2    <= X0;
      r_byp1     <= 1'b0;
      r_byp2     <= 1'b0;
      r_byp_data <= '0;
    end else if (w_gnt_core || w_gnt_dbg) begin
      r_addr1    <= w_cap1;
      r_addr2    <= w_gnt_core ? rd_rs2 : X0;
      r_byp1     <= w_byp1;
      r_byp2     <= w_byp2;
      r_byp_data <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_src1  <= '0;
      r_rsp_src2  <= '0;
      r_dbg_ack   <= 1'b0;
      r_dbg_data  <= '0;
    end else begin
      r_dbg_ack <= 1'b0;
      case (r_state)
        S_CORE_RD: begin
          r_rsp_valid <= 1'b1;
          r_rsp_src1  <= w_src1;
          r_rsp_src2  <= w_src2;
        end
        S_CORE_RSP: if (rsp_ready) r_rsp_valid <= 1'b0;
        S_DBG_RD: begin
          r_dbg_data <= w_src1;
          r_dbg_ack  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_ready  = w_rd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_src1  = r_rsp_src1;
  assign rsp_src2  = r_rsp_src2;
  assign dbg_ack   = r_dbg_ack;
  assign dbg_data  = r_dbg_data;

endmodule

// File: doc/ysyx_24120013_rf_access_ctrl.md
# ysyx_24120013_rf_access_ctrl

Sequencer and arbiter for the NPC general-purpose register file (1 write port, 2 synchronous read ports, 1-cycle read latency, x0 hardwired to zero). It sits between the register file and its three users:
- the IDU operand-read requester, with a valid/ready request and a valid/ready response;
- the WBU write-back port, which is never stalled;
- a single-register debug/difftest read port.

It hides the read latency, forwards a same-edge write-back into the read result, forces x0 to zero and round-robins the read ports between the core and debug.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width

Ports (reset is synchronous and active-high):
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous reset
- rd_valid  in  1  core operand-read request
- rd_ready  out  1  request accepted this cycle when rd_valid && rd_ready
- rd_rs1, rd_rs2  in  ADDR_WIDTH  source register indices
- rsp_valid  out  1  operand response valid
- rsp_ready  in  1  core consumes the response
- rsp_src1, rsp_src2  out  DATA_WIDTH  operand values
- wb_valid  in  1  write-back strobe
- wb_rd  in  ADDR_WIDTH  write-back destination
- wb_data  in  DATA_WIDTH  write-back value
- dbg_req  in  1  debug read request, held high until dbg_ack
- dbg_addr  in  ADDR_WIDTH  debug register index, stable while dbg_req is high
- dbg_ack  out  1  one-cycle pulse; dbg_data is valid in that cycle
- dbg_data  out  DATA_WIDTH  debug read result
- rf_raddr1, rf_raddr2  out  ADDR_WIDTH  to RF read ports
- rf_rdata1, rf_rdata2  in  DATA_WIDTH  from RF, valid the cycle after the address edge
- rf_wen, rf_waddr, rf_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  to RF write port

## Operation
- Write path (combinational, every cycle, independent of FSM state):
  - rf_wen = wb_valid && (wb_rd != 0).
  - rf_waddr = wb_rd; rf_wdata = wb_data.
- FSM states:
  - IDLE:
    - Arbitration uses last_grant, which records who was granted last.
    - If rd_valid and dbg_req are both high, grant the side not in last_grant.
    - Otherwise grant whichever side is requesting.
    - rd_ready = IDLE && grant==core.
    - On a core grant: rf_raddr1/2 = rd_rs1/rd_rs2; capture rs1/rs2 and the bypass info; next state CORE_RD; last_grant=core.
    - On a debug grant: rf_raddr1 = dbg_addr; capture the address and bypass info; next state DBG_RD; last_grant=dbg.
    - With no grant, rf_raddr1/2 = 0.
  - CORE_RD:
    - src1 = rs1==0 ? 0 : byp1 ? byp_data : rf_rdata1 (src2 likewise).
    - Register into rsp_src1/2, set rsp_valid, go to CORE_RSP.
  - CORE_RSP:
    - Hold rsp_valid and the data stable.
    - On rsp_ready, clear rsp_valid and go to IDLE.
  - DBG_RD:
    - Register dbg_data with the same zero/bypass rule, pulse dbg_ack for one cycle, go to IDLE.
- Bypass flag: byp_n = wb_valid && wb_rd==addr_n && addr_n!=0, evaluated in the grant cycle. byp_data = wb_data from that cycle. This is needed because the RF returns the pre-write value when the read and the write share an edge.
- Snapshot semantics: results reflect RF state as of the grant edge, including a write on that same edge. Writes in later cycles are not reflected; hazards belong to the core's scoreboard.
- x0 always reads 0, even before any write has occurred after reset.

## Timing
- Reset values:
  - state=IDLE, last_grant=dbg (so core wins the first tie).
  - rsp_valid=0, rsp_src1/2=0.
  - dbg_ack=0, dbg_data=0.
  - rd_ready is 1 in the first cycle after reset.
- Core latency: accept at edge E0, rsp_valid high after E1. Minimum 3 cycles per request; the next accept happens at the earliest on the edge that consumes the response + 1.
- Debug latency: grant at E0, dbg_ack high for the one cycle after E1. dbg_req may drop in the ack cycle. If it is still high in the following IDLE cycle, that counts as a new request.
- rd_ready is 0 in every non-IDLE state. rd_rs* are sampled only on the accept edge.
- rsp_ready has no effect unless the FSM is in CORE_RSP.
- Reset mid-transaction: the pending response is dropped, no rsp_valid or dbg_ack is produced, and the FSM returns to IDLE. wb writes asserted during rst still pass to the RF.
- Write to x0: rf_wen stays 0 and no bypass is set.

## Test plan
- **Basic read:** reset, then write x5=0x1234 and x6=0xABCD. Request rs1=5, rs2=6 with rsp_ready=1. Expect rsp_valid two edges after accept with src1=0x1234, src2=0xABCD, and rd_ready high again the next cycle.
- **Same-edge bypass:** in the accept cycle of rs1=7, assert wb_valid with wb_rd=7, wb_data=0xDEADBEEF. Expect src1=0xDEADBEEF. A write to x7 one cycle later must not change the held response.
- **x0 handling:** write x0=0xFFFFFFFF. Expect rf_wen=0 that cycle. Read rs1=0, rs2=0; expect src1=src2=0.
- **Backpressure:** hold rsp_ready=0 for 5 cycles. Expect rsp_valid and data to stay stable and rd_ready=0 throughout. Raising rsp_ready drops rsp_valid on the next edge.
- **Arbitration:** hold rd_valid and dbg_req continuously. Expect core to be granted first, then debug, then core again, strictly alternating. Check dbg_data for dbg_addr=5 equals 0x1234, with a single-cycle dbg_ack.
- **Reset mid-op:** assert rst in the CORE_RD cycle. Expect no rsp_valid afterwards and rd_ready=1 in the first cycle after reset deasserts.
